// File: rtl/la_add_seq_pkg.sv
// rtl/la_add_seq_pkg.sv - shared state encodings and default sizing for the sequential lookahead adder
package la_pkg;

    localparam int LA_WIDTH = 32;
    localparam int LA_SLICE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/la_add_seq_if.sv
// rtl/la_add_seq_if.sv - request/result handshake bundle for la_add_seq; port sub exists only with LA_ADD_SEQ_SUB_EN
interface la_add_seq_if #(
    parameter int WIDTH = la_pkg::LA_WIDTH
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef LA_ADD_SEQ_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
`ifdef LA_ADD_SEQ_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
`ifdef LA_ADD_SEQ_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/la_add_seq_slice.sv
// rtl/la_add_seq_slice.sv - combinational SLICE-bit carry-lookahead adder (la_slice)
module la_slice #(
    parameter int SLICE = la_pkg::LA_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             gp,
    output logic             gg,
    output logic             cout
);
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE-1:0] gen_v;
    logic [SLICE-1:0] prop_v;
    logic [SLICE:0]   c;

    // Each carry is the flattened sum-of-products g[i] | p[i]g[i-1] | ... | p[i..0]cin.
    always_comb begin
        p      = a ^ b;
        g      = a & b;
        gen_v  = '0;
        prop_v = '0;
        c      = '0;
        c[0]   = cin;
        for (int i = 0; i < SLICE; i++) begin
            logic gen_t;
            logic prop_t;
            gen_t  = g[i];
            prop_t = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                gen_t  = gen_t | (prop_t & g[j]);
                prop_t = prop_t & p[j];
            end
            gen_v[i]  = gen_t;
            prop_v[i] = prop_t;
            c[i+1]    = gen_t | (prop_t & cin);
        end
        sum  = p ^ c[SLICE-1:0];
        gp   = prop_v[SLICE-1];
        gg   = gen_v[SLICE-1];
        cout = c[SLICE];
    end
endmodule

// File: rtl/la_add_seq.sv
// rtl/la_add_seq.sv - sequential adder reusing one lookahead slice per cycle; subtract mode via LA_ADD_SEQ_SUB_EN
module la_add_seq
    import la_pkg::*;
#(
    parameter int WIDTH = LA_WIDTH,
    parameter int SLICE = LA_SLICE
) (
    input  logic         clk,
    input  logic         rst_n,
    la_add_seq_if.slave  bus
);
    localparam int NSL   = WIDTH / SLICE;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [SLICE-1:0]   op_a, op_b, sl_sum;
    logic               sl_gp, sl_gg, sl_cout;
    logic               accept;
    logic [WIDTH-1:0]   b_in;
    logic               cin_in;

    assign op_a   = a_q[idx_q*SLICE +: SLICE];
    assign op_b   = b_q[idx_q*SLICE +: SLICE];
    assign accept = (state_q == IDLE) && bus.in_valid;

    // Subtraction folds into the add as a + ~b + 1, so the datapath never changes.
`ifdef LA_ADD_SEQ_SUB_EN
    assign b_in   = bus.sub ? ~bus.b : bus.b;
    assign cin_in = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_in   = bus.b;
    assign cin_in = bus.cin;
`endif

    la_slice #(.SLICE(SLICE)) u_slice (
        .a    (op_a),
        .b    (op_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .gp   (sl_gp),
        .gg   (sl_gg),
        .cout (sl_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            idx_d   = '0;
            a_d     = bus.a;
            b_d     = b_in;
            carry_d = cin_in;
            sum_d   = '0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == RUN) begin
            sum_d[idx_q*SLICE +: SLICE] = sl_sum;
            carry_d = sl_cout;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                cout_d = sl_cout;
                // Carry into the MSB is recovered from its sum bit: s = a ^ b ^ c.
                ovf_d  = sl_sum[SLICE-1] ^ op_a[SLICE-1] ^ op_b[SLICE-1] ^ sl_cout;
            end
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.sum       = sum_q;
        bus.cout      = cout_q;
        bus.ovf       = ovf_q;
    end
endmodule

// File: tb/tb_la_add_seq.sv
// tb/tb_la_add_seq.sv - directed self-checking bench for la_add_seq
module tb_la_add_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    la_add_seq_if #(.WIDTH(32)) bus ();

    la_add_seq #(.WIDTH(32), .SLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic cv, output int lat);
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = cv;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.sum !== 32'h0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_out sum=%h cout=%b ovf=%b required 0 0 0", bus.sum, bus.cout, bus.ovf);
        end
    endtask

    task automatic test_basic();
        int lat;
        start_op(32'h1, 32'h2, 1'b0, lat);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL basic_latency got %0d required 8", lat);
        end
        checks++;
        if (bus.sum !== 32'h3 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_result sum=%h cout=%b ovf=%b required 00000003 0 0", bus.sum, bus.cout, bus.ovf);
        end
        finish_op();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_release in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_carry_chain();
        int lat;
        start_op(32'hFFFF_FFFF, 32'h0, 1'b1, lat);
        checks++;
        if (lat !== 8 || bus.sum !== 32'h0 || bus.cout !== 1'b1 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL carry_chain lat=%0d sum=%h cout=%b ovf=%b required 8 00000000 1 0", lat, bus.sum, bus.cout, bus.ovf);
        end
        finish_op();
    endtask

    task automatic test_overflow();
        int lat;
        start_op(32'h7FFF_FFFF, 32'h1, 1'b0, lat);
        checks++;
        if (lat !== 8 || bus.sum !== 32'h8000_0000 || bus.cout !== 1'b0 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow lat=%0d sum=%h cout=%b ovf=%b required 8 80000000 0 1", lat, bus.sum, bus.cout, bus.ovf);
        end
        finish_op();
        start_op(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
        checks++;
        if (bus.sum !== 32'h0 || bus.cout !== 1'b1 || bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL neg_overflow sum=%h cout=%b ovf=%b required 00000000 1 1", bus.sum, bus.cout, bus.ovf);
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, lat);
        bus.a        = 32'h1111_1111;
        bus.b        = 32'h2222_2222;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d out_valid=%b in_ready=%b sum=%h required 1 0 ffffffff", k, bus.out_valid, bus.in_ready, bus.sum);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        finish_op();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL backpressure_release in_ready=%b out_valid=%b sum=%h required 1 0 ffffffff", bus.in_ready, bus.out_valid, bus.sum);
        end
    endtask

    task automatic test_ignore();
        int lat;
        bus.a         = 32'h0000_00F0;
        bus.b         = 32'h0000_0010;
        bus.cin       = 1'b0;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.a         = 32'h1234_5678;
        bus.b         = 32'h1;
        bus.out_ready = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (lat !== 8 || bus.sum !== 32'h0000_0100) begin
            errors++;
            $display("FAIL ignore_inputs lat=%0d sum=%h required 8 00000100", lat, bus.sum);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        bus.a         = 32'h0000_0FFF;
        bus.b         = 32'h0000_0001;
        bus.cin       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        t1 = -1;
        t2 = -1;
        for (int k = 0; k < 60 && t2 < 0; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                if (t1 < 0) begin
                    t1 = k;
                    checks++;
                    if (bus.sum !== 32'h0000_1000) begin
                        errors++;
                        $display("FAIL b2b_first sum=%h required 00001000", bus.sum);
                    end
                    bus.a = 32'h0000_0020;
                    bus.b = 32'h0000_0022;
                    bus.cin = 1'b1;
                end else begin
                    t2 = k;
                    bus.in_valid = 1'b0;
                    checks++;
                    if (bus.sum !== 32'h0000_0043) begin
                        errors++;
                        $display("FAIL b2b_second sum=%h required 00000043", bus.sum);
                    end
                end
            end
        end
        checks++;
        if (t1 < 0 || t2 < 0 || (t2 - t1) !== 10) begin
            errors++;
            $display("FAIL b2b_period t1=%0d t2=%0d period=%0d required 10", t1, t2, t2 - t1);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        bus.a        = 32'h1234_5678;
        bus.b        = 32'h1111_1111;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum !== 32'h0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0 0 0", bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort out_valid seen=%b required 0", seen);
        end
        start_op(32'd5, 32'd7, 1'b0, lat);
        checks++;
        if (lat !== 8 || bus.sum !== 32'd12) begin
            errors++;
            $display("FAIL reset_recover lat=%0d sum=%h required 8 0000000c", lat, bus.sum);
        end
        finish_op();
    endtask

`ifdef LA_ADD_SEQ_SUB_EN
    task automatic test_sub();
        int lat;
        bus.sub = 1'b1;
        start_op(32'd10, 32'd3, 1'b0, lat);
        checks++;
        if (bus.sum !== 32'd7 || bus.cout !== 1'b1) begin
            errors++;
            $display("FAIL sub_pos sum=%h cout=%b required 00000007 1", bus.sum, bus.cout);
        end
        finish_op();
        start_op(32'd3, 32'd10, 1'b1, lat);
        checks++;
        if (bus.sum !== 32'hFFFF_FFF9 || bus.cout !== 1'b0) begin
            errors++;
            $display("FAIL sub_neg sum=%h cout=%b required fffffff9 0", bus.sum, bus.cout);
        end
        finish_op();
        bus.sub = 1'b0;
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
`ifdef LA_ADD_SEQ_SUB_EN
        bus.sub       = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_carry_chain();
        test_overflow();
        test_backpressure();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef LA_ADD_SEQ_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
